// File: rtl/accel_spi3_pkg.sv
// Shared definitions for the 3-wire SPI accelerometer responder: register addresses, FSM states, bit positions.
// Latency: none (types and constants only).
// Backpressure: none.
package accel_spi3_pkg;

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
    localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;
    localparam logic [5:0] ADDR_DATAX1      = 6'h33;
    localparam logic [5:0] ADDR_DATAY0      = 6'h34;
    localparam logic [5:0] ADDR_DATAY1      = 6'h35;
    localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
    localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

    localparam int MEASURE_BIT = 3;
    localparam int DRDY_BIT    = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        RDATA = 2'd2,
        WDATA = 2'd3
    } state_t;

    // True for the six axis-data bytes whose read clears DATA_READY.
    function automatic logic is_data_addr(input logic [5:0] a);
        return (a >= ADDR_DATAX0) && (a <= ADDR_DATAZ1);
    endfunction

endpackage

// File: rtl/accel_spi3_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pad plus rise/fall detection on the synced level.
// Latency: level appears SYNC_STAGES clocks after the pad; rise/fall pulse in that same cycle.
// Backpressure: none; free-running sampler.
module accel_spi3_sync #(
    parameter int   SYNC_STAGES = 2,   // must be at least 2
    parameter logic RST_VAL     = 1'b0 // idle level of the pad
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // Shift the pad through the synchronizer and remember the previous synced level.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {SYNC_STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign q    = chain[SYNC_STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/accel_spi3_responder.sv
// ADXL345-style 3-wire SPI responder (mode 3) with a small register file and XYZ sample buffering.
// Latency: SDAT driven within SYNC_STAGES+1 clocks of an SCLK fall; samples land one clock after the strobe.
// Backpressure: none; a sample arriving mid-frame waits in a one-deep buffer (newest wins) until CS_N rises.
// Optional ACCEL_DRDY_INT_EN: drives spi_int from INT_ENABLE[7] & DATA_READY; otherwise spi_int is 0.
module accel_spi3_responder
    import accel_spi3_pkg::*;
#(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_sdat_in,
    output logic        spi_sdat_out,
    output logic        spi_sdat_oe,
    output logic        spi_int,
    input  logic        sample_valid,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    output logic        measure
);

    // Synced pad levels and edges; the *_unused ones exist only because every pad shares one sync block.
    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic cs_q, cs_rise, cs_fall_unused;
    logic sdat_q, sdat_rise_unused, sdat_fall_unused;

    accel_spi3_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
        .clk(clk_clk), .rst(reset_reset), .din(spi_sclk),
        .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    accel_spi3_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk_clk), .rst(reset_reset), .din(spi_cs_n),
        .q(cs_q), .rise(cs_rise), .fall(cs_fall_unused)
    );

    accel_spi3_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdat (
        .clk(clk_clk), .rst(reset_reset), .din(spi_sdat_in),
        .q(sdat_q), .rise(sdat_rise_unused), .fall(sdat_fall_unused)
    );

    state_t      state, next_state;
    logic [2:0]  bit_cnt;
    logic [6:0]  shift_in;
    logic [7:0]  rx_byte;
    logic        cmd_mb;
    logic [5:0]  addr;
    logic [5:0]  next_addr;
    logic [5:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [7:0]  tx_shift;
    logic        byte_done;
    logic        wr_en;
    logic        rd_done;

    logic [7:0]  bw_rate, power_ctl, int_enable, data_format;
    logic [15:0] data_x, data_y, data_z;
    logic [15:0] pend_x, pend_y, pend_z;
    logic        pend_vld;
    logic        data_ready;
    logic        sample_ok;
    logic        commit_now, commit_pend;

    // Byte being assembled, including the bit arriving on this rising edge.
    assign rx_byte   = {shift_in, sdat_q};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7) && !cs_q;
    assign next_addr = cmd_mb ? (addr + 6'd1) : addr;
    assign wr_en     = (state == WDATA) && byte_done;
    assign rd_done   = (state == RDATA) && byte_done;
    assign measure   = power_ctl[MEASURE_BIT];

    // State register.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) state <= IDLE;
        else             state <= next_state;
    end

    // Next state: CS_N high wins over everything; the command byte picks read or write.
    always_comb begin
        next_state = state;
        if (cs_q) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = CMD;
                CMD:     if (sclk_rise && (bit_cnt == 3'd7))
                             next_state = rx_byte[7] ? RDATA : WDATA;
                default: next_state = state;
            endcase
        end
    end

    // During the command the byte to load comes from the decoded address; afterwards from the next address.
    assign rd_addr = (state == CMD) ? rx_byte[5:0] : next_addr;

    // Register read mux; unmapped addresses return zero.
    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            ADDR_DEVID:       rd_data = DEVID;
            ADDR_BW_RATE:     rd_data = bw_rate;
            ADDR_POWER_CTL:   rd_data = power_ctl;
            ADDR_INT_ENABLE:  rd_data = int_enable;
            ADDR_INT_SOURCE:  rd_data[DRDY_BIT] = data_ready;
            ADDR_DATA_FORMAT: rd_data = data_format;
            ADDR_DATAX0:      rd_data = data_x[7:0];
            ADDR_DATAX1:      rd_data = data_x[15:8];
            ADDR_DATAY0:      rd_data = data_y[7:0];
            ADDR_DATAY1:      rd_data = data_y[15:8];
            ADDR_DATAZ0:      rd_data = data_z[7:0];
            ADDR_DATAZ1:      rd_data = data_z[15:8];
            default:          rd_data = 8'h00;
        endcase
    end

    // Serial engine: shift command/write bits on rising edges, drive read bits on falling edges.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            bit_cnt      <= 3'd0;
            shift_in     <= 7'd0;
            cmd_mb       <= 1'b0;
            addr         <= 6'd0;
            tx_shift     <= 8'h00;
            spi_sdat_out <= 1'b0;
            spi_sdat_oe  <= 1'b0;
        end else if (cs_q) begin
            // Abort or idle: release the line and drop any partial byte.
            bit_cnt      <= 3'd0;
            spi_sdat_out <= 1'b0;
            spi_sdat_oe  <= 1'b0;
        end else begin
            case (state)
                CMD: begin
                    if (sclk_rise) begin
                        shift_in <= rx_byte[6:0];
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            cmd_mb   <= rx_byte[6];
                            addr     <= rx_byte[5:0];
                            tx_shift <= rd_data;
                        end
                    end
                end
                RDATA: begin
                    if (sclk_fall) begin
                        spi_sdat_out <= tx_shift[7];
                        spi_sdat_oe  <= 1'b1;
                        tx_shift     <= {tx_shift[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            // Master has sampled the last bit; release until the next byte starts.
                            spi_sdat_oe <= 1'b0;
                            addr        <= next_addr;
                            tx_shift    <= rd_data;
                        end
                    end
                end
                WDATA: begin
                    if (sclk_rise) begin
                        shift_in <= rx_byte[6:0];
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) addr <= next_addr;
                    end
                end
                default: bit_cnt <= 3'd0;
            endcase
        end
    end

    // A sample lands directly while deselected; otherwise the buffered one lands as CS_N rises.
    assign sample_ok   = sample_valid && power_ctl[MEASURE_BIT];
    assign commit_now  = sample_ok && cs_q;
    assign commit_pend = !commit_now && cs_rise && pend_vld;

    // Register file, sample buffering and DATA_READY.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            bw_rate     <= BW_RATE_RST;
            power_ctl   <= 8'h00;
            int_enable  <= 8'h00;
            data_format <= 8'h00;
            data_x      <= 16'h0000;
            data_y      <= 16'h0000;
            data_z      <= 16'h0000;
            pend_x      <= 16'h0000;
            pend_y      <= 16'h0000;
            pend_z      <= 16'h0000;
            pend_vld    <= 1'b0;
            data_ready  <= 1'b0;
        end else begin
            if (wr_en) begin
                case (addr)
                    ADDR_BW_RATE:     bw_rate     <= rx_byte;
                    ADDR_POWER_CTL:   power_ctl   <= rx_byte;
                    ADDR_INT_ENABLE:  int_enable  <= rx_byte;
                    ADDR_DATA_FORMAT: data_format <= rx_byte;
                    default: ;
                endcase
            end

            if (commit_now) begin
                data_x <= sample_x;
                data_y <= sample_y;
                data_z <= sample_z;
            end else if (commit_pend) begin
                data_x <= pend_x;
                data_y <= pend_y;
                data_z <= pend_z;
            end

            if (sample_ok && !cs_q) begin
                pend_x   <= sample_x;
                pend_y   <= sample_y;
                pend_z   <= sample_z;
                pend_vld <= 1'b1;
            end else if (cs_rise || commit_now) begin
                pend_vld <= 1'b0;
            end

            // A commit in the same cycle as a clearing read leaves DATA_READY set.
            if (commit_now || commit_pend)
                data_ready <= 1'b1;
            else if (rd_done && is_data_addr(addr))
                data_ready <= 1'b0;
        end
    end

`ifdef ACCEL_DRDY_INT_EN
    // Data-ready interrupt, registered one clock behind DATA_READY.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) spi_int <= 1'b0;
        else             spi_int <= int_enable[DRDY_BIT] & data_ready;
    end
`else
    assign spi_int = 1'b0;
`endif

endmodule
